// File: rtl/motion_pkg.sv
// Shared types and constants for the motion pipeline.
package motion_pkg;

  localparam int WP     = 32;
  localparam int Q_FRAC = 16;

  localparam logic [WP-1:0] DT_MAX_DEFAULT = 32'h0000_1000;

  typedef struct packed {
    logic signed [WP-1:0] x;
    logic signed [WP-1:0] y;
    logic signed [WP-1:0] z;
    logic signed [WP-1:0] dt;
    logic                 sof;
  } pt_entry_t;

endpackage

// File: rtl/point_dt_sequencer_fifo.sv
// Synchronous FIFO of pt_entry_t with a registered head entry.
module pds_fifo
  import motion_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  pt_entry_t wdata,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output pt_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  pt_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  pt_entry_t     head_q, head_d;

  logic        push_ok, pop_ok;
  logic [AW:0] remain;

  assign full    = cnt_q[AW];
  assign empty   = (cnt_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = head_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    cnt_d    = cnt_q + (AW+1)'(push_ok)
                     - (AW+1)'(pop_ok);
    remain   = cnt_q - (AW+1)'(pop_ok);
    head_d   = head_q;
    // Head shadows mem[rd_ptr]; a lone pushed entry bypasses the array
    if (cnt_d != '0) begin
      if (remain == '0) head_d = wdata;
      else              head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/point_dt_sequencer.sv
// Point feeder: dt from timestamps, FIFO, velocity register.
// Option: POINT_DT_SEQUENCER_DT_CLAMP_EN clamps dt to DT_MAX.
module point_dt_sequencer
  import motion_pkg::*;
#(
  parameter int            DEPTH  = 4,
  parameter logic [WP-1:0] DT_MAX = DT_MAX_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WP-1:0] in_x,
  input  logic [WP-1:0] in_y,
  input  logic [WP-1:0] in_z,
  input  logic [WP-1:0] in_ts,
  input  logic          in_sof,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WP-1:0] px,
  output logic [WP-1:0] py,
  output logic [WP-1:0] pz,
  output logic [WP-1:0] dt,
  output logic [WP-1:0] v_prev,
  input  logic [WP-1:0] v_next,
  output logic          err_ts,
  output logic [15:0]   dt_sat_cnt
);

  logic          first_q, first_d;
  logic [WP-1:0] last_ts_q, last_ts_d;
  logic [WP-1:0] v_reg_q, v_reg_d;
  logic          err_q, err_d;

  logic          full, empty, push, pop;
  logic          back, sat;
  logic [WP-1:0] dt_raw, dt_c;
  pt_entry_t     wdata, head;

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign dt_raw    = in_ts - last_ts_q;

  always_comb begin
    back = 1'b0;
    sat  = 1'b0;
    dt_c = '0;
    if (first_q || in_sof) begin
      dt_c = '0;
    end else if ($signed(in_ts) < $signed(last_ts_q)) begin
      back = 1'b1;
    end else begin
      dt_c = dt_raw;
`ifdef POINT_DT_SEQUENCER_DT_CLAMP_EN
      if ($signed(dt_raw) > $signed(DT_MAX)) begin
        dt_c = DT_MAX;
        sat  = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    wdata.x   = in_x;
    wdata.y   = in_y;
    wdata.z   = in_z;
    wdata.dt  = dt_c;
    wdata.sof = in_sof;
  end

  always_comb begin
    first_d   = first_q;
    last_ts_d = last_ts_q;
    err_d     = err_q;
    v_reg_d   = v_reg_q;
    if (push) begin
      first_d   = 1'b0;
      last_ts_d = in_ts;
      err_d     = err_q | back;
    end
    if (pop) v_reg_d = v_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q   <= 1'b1;
      last_ts_q <= '0;
      err_q     <= 1'b0;
      v_reg_q   <= '0;
    end else begin
      first_q   <= first_d;
      last_ts_q <= last_ts_d;
      err_q     <= err_d;
      v_reg_q   <= v_reg_d;
    end
  end

`ifdef POINT_DT_SEQUENCER_DT_CLAMP_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (push && sat && sat_cnt_q != 16'hFFFF)
      sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_cnt_q <= '0;
    else     sat_cnt_q <= sat_cnt_d;
  end

  assign dt_sat_cnt = sat_cnt_q;
`else
  logic unused_clamp;
  assign unused_clamp = ^{DT_MAX, sat};
  assign dt_sat_cnt   = '0;
`endif

  pds_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign px     = head.x;
  assign py     = head.y;
  assign pz     = head.z;
  assign dt     = head.dt;
  assign v_prev = head.sof ? '0 : v_reg_q;
  assign err_ts = err_q;

endmodule

// File: tb/tb_point_dt_sequencer.sv
// Scoreboard bench for point_dt_sequencer.
module tb_point_dt_sequencer;

  typedef struct {
    logic [31:0] x, y, z, dt;
    logic        sof;
  } exp_t;

  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_ready;
  logic [31:0] in_x = 0, in_y = 0, in_z = 0, in_ts = 0;
  logic        in_sof = 0;
  logic        out_valid, out_ready = 0;
  logic [31:0] px, py, pz, dt, v_prev, v_next;
  logic        err_ts;
  logic [15:0] dt_sat_cnt;

  int checks = 0, errors = 0;
  exp_t exp_q[$];
  logic [31:0] model_v = 0;

  assign v_next = v_prev + 32'h18000;

  always #5 clk = ~clk;

  point_dt_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .in_ts(in_ts), .in_sof(in_sof),
    .out_valid(out_valid), .out_ready(out_ready),
    .px(px), .py(py), .pz(pz), .dt(dt),
    .v_prev(v_prev), .v_next(v_next),
    .err_ts(err_ts), .dt_sat_cnt(dt_sat_cnt)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] x, input logic [31:0] ts,
                      input logic sof, input logic [31:0] edt);
    int n = 0;
    exp_t e;
    in_valid = 1; in_x = x; in_y = x + 1; in_z = x + 2;
    in_ts = ts; in_sof = sof;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout: x=%h never accepted", x);
      in_valid = 0;
      return;
    end
    @(posedge clk);
    e.x = x; e.y = x + 1; e.z = x + 2; e.dt = edt; e.sof = sof;
    exp_q.push_back(e);
    #1 in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries left, expected 0",
               exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out: px=%h with empty scoreboard", px);
      end else begin
        exp_t e;
        logic [31:0] ev;
        e = exp_q.pop_front();
        ev = e.sof ? 32'h0 : model_v;
        chk("px", px, e.x);
        chk("py", py, e.y);
        chk("pz", pz, e.z);
        chk("dt", dt, e.dt);
        chk("v_prev", v_prev, ev);
        model_v = ev + 32'h18000;
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_px", px, 0);
    chk("rst_dt", dt, 0);
    chk("rst_v_prev", v_prev, 0);
    chk("rst_err_ts", {31'b0, err_ts}, 0);
    chk("rst_sat_cnt", {16'b0, dt_sat_cnt}, 0);
    rst = 0;
    @(posedge clk); #1;

    // dt sequence and velocity chain
    out_ready = 1;
    push(32'h100, 32'h0,   0, 32'h0);
    chk("lat_ov1", {31'b0, out_valid}, 1);
    push(32'h200, 32'h28F, 0, 32'h28F);
    chk("lat_ov2", {31'b0, out_valid}, 1);
    push(32'h300, 32'h7AE, 0, 32'h51F);
    chk("lat_ov3", {31'b0, out_valid}, 1);
    push(32'h400, 32'h800, 1, 32'h0);
    drain();
    chk("empty_ov", {31'b0, out_valid}, 0);

    // backpressure
    out_ready = 0;
    push(32'h500, 32'h900, 0, 32'h100);
    push(32'h600, 32'hA00, 0, 32'h100);
    push(32'h700, 32'hB00, 0, 32'h100);
    push(32'h800, 32'hC00, 0, 32'h100);
    chk("full_in_ready", {31'b0, in_ready}, 0);
    chk("full_head", px, 32'h500);
    fork
      push(32'h900, 32'hD00, 0, 32'h100);
      begin
        repeat (3) @(posedge clk);
        #2;
        chk("full_hold", {31'b0, in_ready}, 0);
        chk("full_head_stable", px, 32'h500);
        out_ready = 1;
      end
    join
    drain();

    // backwards timestamp
    push(32'hA00, 32'h10000, 1, 32'h0);
    push(32'hB00, 32'h8000,  0, 32'h0);
    chk("err_set", {31'b0, err_ts}, 1);
    push(32'hC00, 32'h9000, 0, 32'h1000);
    for (int i = 1; i < 10; i++)
      push(32'hC00 + i, 32'h9000 + i * 32'h100, 0, 32'h100);
    drain();
    chk("err_sticky", {31'b0, err_ts}, 1);

    // clamp
    push(32'hD00, 32'h0, 1, 32'h0);
`ifdef POINT_DT_SEQUENCER_DT_CLAMP_EN
    push(32'hD01, 32'h2000, 0, 32'h1000);
    chk("sat_cnt", {16'b0, dt_sat_cnt}, 1);
`else
    push(32'hD01, 32'h2000, 0, 32'h2000);
    chk("sat_cnt", {16'b0, dt_sat_cnt}, 0);
`endif
    drain();

    // mid-stream reset
    rst = 1; exp_q.delete(); model_v = 0;
    @(posedge clk); #1 rst = 0;
    chk("rst2_err_ts", {31'b0, err_ts}, 0);
    push(32'hE00, 32'h100, 0, 32'h0);
    push(32'hE01, 32'h200, 0, 32'h100);
    drain();
    out_ready = 0;
    push(32'hE02, 32'h300, 0, 32'h100);
    push(32'hE03, 32'h400, 0, 32'h100);
    push(32'hE04, 32'h500, 0, 32'h100);
    chk("pre_rst_v_prev", v_prev, 32'h30000);
    rst = 1; exp_q.delete(); model_v = 0;
    #1;
    chk("mid_rst_ov", {31'b0, out_valid}, 0);
    chk("mid_rst_v_prev", v_prev, 0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 1);
    @(posedge clk); #1 rst = 0;
    out_ready = 1;
    push(32'hF00, 32'h5000, 0, 32'h0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/point_dt_sequencer.md
# point_dt_sequencer

Upstream feeder for the motion corrector. Accepts a valid/ready stream of timestamped Q16.16 points and computes `dt` from consecutive timestamps. Buffers points in a small FIFO and presents `px/py/pz/dt` together with the velocity state `v_prev`. It owns the velocity register that was previously held by the bench, updating it from the corrector's `v_next` on every output handshake.

## Interface
- `WP`, 32, word width; all data is signed Q16.16.
- `DEPTH`, 4, FIFO entries (power of two, ≥2).
- `DT_MAX`, 32'h0000_1000 (0.0625 s), clamp ceiling for `dt` (used only with clamp enabled).

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input point valid.
- `in_ready`  out  1  space available.
- `in_x`, `in_y`, `in_z`  in  WP  point coordinates.
- `in_ts`  in  WP  absolute timestamp, seconds, Q16.16.
- `in_sof`  in  1  first point of a new frame.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer accepts.
- `px`, `py`, `pz`, `dt`  out  WP  to corrector.
- `v_prev`  out  WP  velocity to corrector.
- `v_next`  in  WP  corrector result for the current head.
- `err_ts`  out  1  sticky: a timestamp went backwards.
- `dt_sat_cnt`  out  16  count of clamped `dt` values; saturates at 0xFFFF.

## Operation
- Input handshake is `in_valid & in_ready`; output handshake is `out_valid & out_ready`.
- At input handshake the block computes `dt`, then pushes {x, y, z, dt, sof} into the FIFO. `last_ts` is updated to `in_ts`.
- `dt` rules, in priority order:
  - first point after reset, or `in_sof=1`: `dt = 0`;
  - `in_ts < last_ts` (signed compare): `dt = 0` and `err_ts` is set;
  - otherwise `dt = in_ts - last_ts`, a WP-bit signed subtract. The result is non-negative by construction.
- Velocity register `v_reg`:
  - `v_prev = head.sof ? 0 : v_reg`;
  - on output handshake, `v_reg <= v_next`.
  - `v_next` is sampled combinationally from the corrector in the same cycle.
- `err_ts` clears only on `rst`.
- Output fields come straight from the FIFO head register. When `out_valid=0`, outputs hold their last value.

## Timing
- Reset values:
  - `in_ready=1`, `out_valid=0`;
  - `px/py/pz/dt/v_prev = 0`;
  - `err_ts=0`, `dt_sat_cnt=0`;
  - `v_reg=0`, `last_ts=0`, first-point flag set.
- Latency: input accepted at edge N means the entry is visible with `out_valid=1` after edge N (cycle N+1). There is no combinational path from `in_*` to `out_*`.
- `in_ready = (count < DEPTH)`. A push and a pop in the same cycle is legal when not full, and `count` is unchanged. When full, no push is accepted even if a pop occurs that cycle.
- Empty: `out_valid=0`; `v_reg` does not change.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally; `count` is `$clog2(DEPTH)+1` bits.
- `in_valid` may drop without handshake; `in_*` is don't-care when `in_valid=0`.
- Once `out_valid=1`, head fields are stable until the handshake completes.
- Reset asserted mid-stream flushes the FIFO, zeroes `v_reg`, and rearms the first-point flag in the same cycle.

## Configuration
- `POINT_DT_SEQUENCER_DT_CLAMP_EN` defined:
  - a computed positive `dt > DT_MAX` is replaced by `DT_MAX`;
  - `dt_sat_cnt` increments at that input handshake.
- Not defined:
  - `dt` is passed unclamped;
  - `dt_sat_cnt` is tied to 0;
  - `DT_MAX` is unused.

## Structure
- Shared package `motion_pkg` holds:
  - constants `WP=32` and `Q_FRAC=16`;
  - `typedef struct packed { x, y, z, dt; logic sof; } pt_entry_t`;
  - Q16.16 constant `DT_MAX_DEFAULT`.
- Sub-module `pds_fifo`: a parameterised synchronous FIFO of `pt_entry_t` with registered head. It has no knowledge of `dt` or velocity.
- Top level contains the `dt` compute, clamp, `last_ts`, `v_reg`, and the flags.

## Test plan
- Reset then three points with ts 0.0, 0.01, 0.03 (0x0, 0x28F, 0x7AE), `out_ready=1` → `dt` = 0, 0x28F, 0x51F; `out_valid` one cycle after each push.
- Velocity chain: tie `v_next = v_prev + 0x18000` (1.5 × dt stub, fixed) over 3 pops → `v_prev` = 0, 0x18000, 0x30000. Then an `in_sof` point → `v_prev = 0`.
- Backpressure: `out_ready=0`, push 5 points with `DEPTH=4` → `in_ready` low after 4 pushes; 5th accepted only after the first pop; order is preserved.
- Backwards timestamp: ts 0x10000 then 0x8000 → second `dt=0`; `err_ts` goes to 1 and stays 1 through 10 further normal points.
- With clamp enabled: ts 0 then 0x2000 (`DT_MAX`=0x1000) → `dt=0x1000` and `dt_sat_cnt=1`. Without the macro → `dt=0x2000` and the count stays 0.
- Assert `rst` with 3 entries queued and `v_reg=0x30000` → `out_valid=0` and `v_prev=0` immediately. The next point gets `dt=0`.
